// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use hazard detection
//
// Purpose:
//   Captures the ID-stage decode outputs and presents them to EX. Detects
//   load-use hazards against the instruction currently held in EX. On a
//   hazard it stalls IF/ID and inserts a bubble. It also applies EX flushes
//   and downstream back-pressure, and counts inserted bubbles with a
//   saturating counter.
//
// Ports:
//   i_clk, i_reset          clock (rising edge), async active-high reset
//   i_valid                 ID holds a valid instruction
//   i_opcode .. i_imm       decoded instruction fields
//   i_signal_control_mult_A/B, i_mem_read
//                           EX operand-mux selects and load flag
//   i_flush                 EX redirect: kill the instruction being captured
//   i_ex_ready              EX accepts a new instruction this cycle
//   o_*                     registered copies presented to EX
//   o_stall_id              combinational: hold PC and IF/ID this cycle
//   o_bubble_cnt            saturating count of inserted bubbles

module id_ex_stage_reg #(
   parameter int NB_OPCODE = 6,
   parameter int NB_REG    = 5,
   parameter int NB_DATA   = 32,
   parameter int NB_IMM    = 16,
   parameter int NB_CNT    = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_valid,
   input  logic [NB_OPCODE-1:0] i_opcode,
   input  logic [NB_REG-1:0]    i_rs,
   input  logic [NB_REG-1:0]    i_rt,
   input  logic [NB_REG-1:0]    i_rd,
   input  logic [NB_DATA-1:0]   i_data_a,
   input  logic [NB_DATA-1:0]   i_data_b,
   input  logic [NB_IMM-1:0]    i_imm,
   input  logic                 i_signal_control_mult_A,
   input  logic                 i_signal_control_mult_B,
   input  logic                 i_mem_read,
   input  logic                 i_flush,
   input  logic                 i_ex_ready,
   output logic                 o_valid,
   output logic [NB_OPCODE-1:0] o_opcode,
   output logic [NB_REG-1:0]    o_rs,
   output logic [NB_REG-1:0]    o_rt,
   output logic [NB_REG-1:0]    o_rd,
   output logic [NB_DATA-1:0]   o_data_a,
   output logic [NB_DATA-1:0]   o_data_b,
   output logic [NB_IMM-1:0]    o_imm,
   output logic                 o_signal_control_mult_A,
   output logic                 o_signal_control_mult_B,
   output logic                 o_mem_read,
   output logic                 o_stall_id,
   output logic [NB_CNT-1:0]    o_bubble_cnt
);

   localparam logic [NB_CNT-1:0] CNT_MAX = '1;
   localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

   logic                 valid_q,    valid_d;
   logic [NB_OPCODE-1:0] opcode_q,   opcode_d;
   logic [NB_REG-1:0]    rs_q,       rs_d;
   logic [NB_REG-1:0]    rt_q,       rt_d;
   logic [NB_REG-1:0]    rd_q,       rd_d;
   logic [NB_DATA-1:0]   data_a_q,   data_a_d;
   logic [NB_DATA-1:0]   data_b_q,   data_b_d;
   logic [NB_IMM-1:0]    imm_q,      imm_d;
   logic                 mult_a_q,   mult_a_d;
   logic                 mult_b_q,   mult_b_d;
   logic                 mem_read_q, mem_read_d;
   logic [NB_CNT-1:0]    cnt_q,      cnt_d;

   logic hz;
   logic rs_match;
   logic rt_match;

   // A load in EX conflicts with the instruction in ID when ID reads the
   // load's destination. rt only counts as a source when operand B selects
   // the register rather than the immediate. Register 0 is hardwired zero.
   always_comb begin
      rs_match = (rt_q == i_rs);
      rt_match = i_signal_control_mult_B & (rt_q == i_rt);
      hz       = valid_q & mem_read_q & i_valid & (rs_match | rt_match)
                 & (rt_q != '0);
   end

   assign o_stall_id = ~i_reset & (hz | ~i_ex_ready);

   always_comb begin
      valid_d    = valid_q;
      opcode_d   = opcode_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      data_a_d   = data_a_q;
      data_b_d   = data_b_q;
      imm_d      = imm_q;
      mult_a_d   = mult_a_q;
      mult_b_d   = mult_b_q;
      mem_read_d = mem_read_q;
      cnt_d      = cnt_q;

      if (i_flush) begin
         // Killed slot: only the qualifiers matter, the payload is left as is.
         valid_d    = 1'b0;
         mem_read_d = 1'b0;
      end else if (!i_ex_ready) begin
         // Back-pressure: hold everything.
      end else if (hz) begin
         // Bubble. Clearing mem_read drops the hazard on the next cycle so
         // the dependent instruction is captured after exactly one bubble.
         valid_d    = 1'b0;
         mem_read_d = 1'b0;
         mult_a_d   = 1'b0;
         mult_b_d   = 1'b0;
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         valid_d    = i_valid;
         opcode_d   = i_opcode;
         rs_d       = i_rs;
         rt_d       = i_rt;
         rd_d       = i_rd;
         data_a_d   = i_data_a;
         data_b_d   = i_data_b;
         imm_d      = i_imm;
         mult_a_d   = i_signal_control_mult_A;
         mult_b_d   = i_signal_control_mult_B;
         mem_read_d = i_mem_read;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         valid_q    <= 1'b0;
         opcode_q   <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         data_a_q   <= '0;
         data_b_q   <= '0;
         imm_q      <= '0;
         mult_a_q   <= 1'b0;
         mult_b_q   <= 1'b0;
         mem_read_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         opcode_q   <= opcode_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         data_a_q   <= data_a_d;
         data_b_q   <= data_b_d;
         imm_q      <= imm_d;
         mult_a_q   <= mult_a_d;
         mult_b_q   <= mult_b_d;
         mem_read_q <= mem_read_d;
         cnt_q      <= cnt_d;
      end
   end

   assign o_valid                 = valid_q;
   assign o_opcode                = opcode_q;
   assign o_rs                    = rs_q;
   assign o_rt                    = rt_q;
   assign o_rd                    = rd_q;
   assign o_data_a                = data_a_q;
   assign o_data_b                = data_b_q;
   assign o_imm                   = imm_q;
   assign o_signal_control_mult_A = mult_a_q;
   assign o_signal_control_mult_B = mult_b_q;
   assign o_mem_read              = mem_read_q;
   assign o_bubble_cnt            = cnt_q;

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register that captures the ID-stage decode outputs (opcode, register indices, operands, immediate, operand-mux control signals) and presents them to the EX stage.
- Contains the load-use hazard detector: it stalls IF/ID and inserts a bubble into EX.
- Applies EX-stage flushes and downstream back-pressure.
- Keeps a saturating bubble counter for performance debug.

Parameters:
NB_OPCODE, 6, opcode width
NB_REG, 5, register index width
NB_DATA, 32, operand width
NB_IMM, 16, immediate width
NB_CNT, 16, bubble counter width

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_valid  input  1  ID holds a valid instruction
i_opcode  input  NB_OPCODE  decoded opcode
i_rs  input  NB_REG  source register A index
i_rt  input  NB_REG  source register B index / load destination
i_rd  input  NB_REG  R-type destination index
i_data_a  input  NB_DATA  register file read A
i_data_b  input  NB_DATA  register file read B
i_imm  input  NB_IMM  immediate field
i_signal_control_mult_A  input  1  EX operand-A mux select from ID control
i_signal_control_mult_B  input  1  EX operand-B mux select (1 = rt register, 0 = immediate)
i_mem_read  input  1  instruction is a load
i_flush  input  1  EX redirect; kill the instruction being captured
i_ex_ready  input  1  EX accepts a new instruction this cycle
o_valid  output  1  EX-side instruction valid
o_opcode, o_rs, o_rt, o_rd, o_data_a, o_data_b, o_imm  output  same widths  registered copies
o_signal_control_mult_A, o_signal_control_mult_B, o_mem_read  output  1  registered controls
o_stall_id  output  1  combinational; hold PC and IF/ID this cycle
o_bubble_cnt  output  NB_CNT  number of inserted bubbles, saturating

Behaviour:
- Reset (async, i_reset=1): all registered outputs go to 0 immediately, including o_valid=0 and o_bubble_cnt=0. While reset is asserted, o_stall_id=0.
- Hazard (combinational):
  - hz = o_valid & o_mem_read & i_valid & ((o_rt==i_rs) | (i_signal_control_mult_B & (o_rt==i_rt))) & (o_rt!=0).
  - Register 0 never causes a hazard.
- o_stall_id = hz | ~i_ex_ready.
- Per rising edge, highest priority first:
  1. i_flush=1: o_valid<=0, o_mem_read<=0, and the other fields are don't-care. Flush wins over a stall. The bubble counter does not increment.
  2. i_ex_ready=0: every register holds its value.
  3. hz=1: insert a bubble. o_valid<=0, o_mem_read<=0, o_signal_control_mult_A/B<=0. o_bubble_cnt increments by 1 and saturates at all-ones.
  4. Otherwise: capture all inputs, with o_valid<=i_valid.
- Load latency is 1 cycle when there is no stall.
- A load-use pair produces exactly one bubble. On the cycle after the bubble, o_valid=0 and o_mem_read=0, so hz deasserts and the dependent instruction is captured.
- Captured fields are not gated by i_valid. With i_valid=0, o_valid=0 and the data may carry any value.
- Back-to-back loads where the second depends on the first still produce one bubble.
- A reset asserted mid-stall clears everything. After release, the first edge is a plain capture.

Test Plan:
- Reset, then an R-type with rs=3, rt=4, data_a=0x11, data_b=0x22, ex_ready=1 → one edge later o_valid=1, o_data_a=0x11, o_data_b=0x22, mult_A=mult_B=1, o_stall_id=0.
- Load with rt=5 captured, then ID presents R-type rs=5 → o_stall_id=1 for 1 cycle, o_valid=0 bubble, o_bubble_cnt=1; next edge captures the R-type with o_valid=1.
- Load with rt=5, then I-type with rt=5, mult_B=0, rs=2 → no hazard, no bubble, count stays 0. Load with rt=0 followed by rs=0 → no hazard.
- ex_ready=0 for 3 cycles with a valid instruction held → outputs unchanged and o_stall_id=1 throughout; on release, the next instruction is captured.
- i_flush=1 coincident with a hazard and with ex_ready=0 → o_valid=0 after the edge and o_bubble_cnt unchanged.
- Force 2^NB_CNT+3 hazards (use NB_CNT=4 with 19 hazards) → o_bubble_cnt=15 saturated. Assert i_reset asynchronously mid-run → all outputs 0 before the next clock edge.
